// File: rtl/muldiv_unit_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input muldiv_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // MUL returns only the low word, which is identical for signed and unsigned operands.
    function automatic logic op_src1_signed(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_src2_signed(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response valid-ready channels between the execute stage and muldiv_unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    import muldiv_unit_pkg::*;

    logic            req_valid;
    logic            req_ready;
    muldiv_op_t      req_op;
    logic [XLEN-1:0] req_src1;
    logic [XLEN-1:0] req_src2;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic            resp_zero;

    modport master (
        output req_valid, req_op, req_src1, req_src2, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_zero
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, resp_ready,
        output req_ready, resp_valid, resp_result, resp_zero
    );

endinterface

// File: rtl/muldiv_step.sv
// One shift-add multiply iteration or one restoring-divide iteration; chained
// STEPS_PER_CYCLE times inside muldiv_unit.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_mul,
    input  logic [XLEN:0]   acc_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opb_i,
    output logic [XLEN:0]   acc_o,
    output logic [XLEN-1:0] lo_o
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    // Multiply: {acc, lo} is the product register, multiplier bits leave from lo[0].
    // Divide: acc is the partial remainder, dividend bits leave from lo's MSB while
    // quotient bits enter at lo[0].
    always_comb begin
        sum     = lo_i[0] ? (acc_i + {1'b0, opb_i}) : acc_i;
        shifted = {acc_i[XLEN-1:0], lo_i[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, opb_i};
        if (is_mul) begin
            acc_o = {1'b0, sum[XLEN:1]};
            lo_o  = {sum[0], lo_i[XLEN-1:1]};
        end else if (!diff[XLEN+1]) begin
            acc_o = diff[XLEN:0];
            lo_o  = {lo_i[XLEN-2:0], 1'b1};
        end else begin
            acc_o = shifted;
            lo_o  = {lo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// retiring STEPS_PER_CYCLE iterations per clock behind valid/ready channels.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    muldiv_unit_if.slave bus,
    output logic         busy
);
    localparam int N     = XLEN / STEPS_PER_CYCLE;
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    if (!((STEPS_PER_CYCLE == 1) || (STEPS_PER_CYCLE == 2) || (STEPS_PER_CYCLE == 4) ||
          (STEPS_PER_CYCLE == 8)) || ((XLEN % STEPS_PER_CYCLE) != 0)) begin : g_bad_steps
        $error("muldiv_unit: STEPS_PER_CYCLE must be 1, 2, 4 or 8 and divide XLEN");
    end

    muldiv_state_t   state_q, state_d;
    muldiv_op_t      op_q, op_d;
    logic [XLEN:0]   acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic            neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    logic            accept;
    logic            last_iter;
    logic            is_mul;
    logic            sign1, sign2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_result;

    logic [XLEN:0]     acc_chain [STEPS_PER_CYCLE+1];
    logic [XLEN-1:0]   lo_chain  [STEPS_PER_CYCLE+1];
    logic [XLEN:0]     acc_n;
    logic [XLEN-1:0]   lo_n;
    logic [2*XLEN-1:0] prod_mag, prod;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   final_result;

    assign accept    = (state_q == IDLE) && bus.req_valid && !flush;
    assign last_iter = (cnt_q == CNT_W'(1)) || (cnt_q == '0);
    assign is_mul    = !op_is_div(op_q);

    // Magnitudes and the RISC-V special cases are resolved while the request is presented.
    always_comb begin
        sign1    = op_src1_signed(bus.req_op) && bus.req_src1[XLEN-1];
        sign2    = op_src2_signed(bus.req_op) && bus.req_src2[XLEN-1];
        mag1     = sign1 ? -bus.req_src1 : bus.req_src1;
        mag2     = sign2 ? -bus.req_src2 : bus.req_src2;
        div_zero = op_is_div(bus.req_op) && (bus.req_src2 == '0);
        div_ovf  = ((bus.req_op == OP_DIV) || (bus.req_op == OP_REM)) &&
                   (bus.req_src1 == MOST_NEG) && (bus.req_src2 == '1);
        fast     = div_zero || div_ovf;
        if (div_zero) begin
            fast_result = op_is_rem(bus.req_op) ? bus.req_src1 : '1;
        end else begin
            fast_result = op_is_rem(bus.req_op) ? '0 : bus.req_src1;
        end
    end

    assign acc_chain[0] = acc_q;
    assign lo_chain[0]  = lo_q;

    for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .is_mul (is_mul),
            .acc_i  (acc_chain[i]),
            .lo_i   (lo_chain[i]),
            .opb_i  (opb_q),
            .acc_o  (acc_chain[i+1]),
            .lo_o   (lo_chain[i+1])
        );
    end

    assign acc_n = acc_chain[STEPS_PER_CYCLE];
    assign lo_n  = lo_chain[STEPS_PER_CYCLE];

    // neg_q already encodes the op-specific sign rule, so one flag serves every op.
    always_comb begin
        prod_mag = {acc_n[XLEN-1:0], lo_n};
        prod     = neg_q ? -prod_mag : prod_mag;
        quo      = neg_q ? -lo_n : lo_n;
        rem      = neg_q ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
        case (op_q)
            OP_MUL:                     final_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            final_result = quo;
            default:                    final_result = rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.req_valid) state_d = fast ? DONE : BUSY;
                BUSY:    if (last_iter) state_d = DONE;
                DONE:    if (bus.resp_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = (state_q == DONE);
        busy           = (state_q != IDLE);
    end

    assign bus.resp_result = result_q;
    assign bus.resp_zero   = zero_q;

    always_comb begin
        op_d     = op_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        if (accept) begin
            op_d  = bus.req_op;
            acc_d = '0;
            cnt_d = CNT_INIT;
            if (op_is_div(bus.req_op)) begin
                lo_d  = mag1;
                opb_d = mag2;
                neg_d = op_is_rem(bus.req_op) ? sign1 : (sign1 ^ sign2);
            end else begin
                lo_d  = mag2;
                opb_d = mag1;
                neg_d = sign1 ^ sign2;
            end
            if (fast) begin
                result_d = fast_result;
                zero_d   = (fast_result == '0);
            end
        end else if ((state_q == BUSY) && !flush) begin
            acc_d = acc_n;
            lo_d  = lo_n;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (last_iter) begin
                result_d = final_result;
                zero_d   = (final_result == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_MUL;
            acc_q    <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            op_q     <= op_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Drives identical traffic into a 1-step and a 4-step muldiv_unit and checks both
// against a plain-arithmetic RV32M reference and hand-computed vectors.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT1 = XLEN / 1 + 1;
    localparam int LAT4 = XLEN / 4 + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    muldiv_op_t  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        resp_ready;
    logic        busy1, busy4;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit_if #(.XLEN(XLEN)) bus1 ();
    muldiv_unit_if #(.XLEN(XLEN)) bus4 ();

    assign bus1.req_valid  = req_valid;
    assign bus1.req_op     = req_op;
    assign bus1.req_src1   = req_src1;
    assign bus1.req_src2   = req_src2;
    assign bus1.resp_ready = resp_ready;
    assign bus4.req_valid  = req_valid;
    assign bus4.req_op     = req_op;
    assign bus4.req_src1   = req_src1;
    assign bus4.req_src2   = req_src2;
    assign bus4.resp_ready = resp_ready;

    muldiv_unit #(.XLEN(XLEN), .STEPS_PER_CYCLE(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus1),
        .busy  (busy1)
    );

    muldiv_unit #(.XLEN(XLEN), .STEPS_PER_CYCLE(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus4),
        .busy  (busy4)
    );

    always #5 clk = ~clk;

    typedef struct {
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        fast;
    } vec_t;

    vec_t vecs [16];

    // RV32M results from 64-bit host arithmetic, including the defined divide corner cases.
    function automatic logic [31:0] ref_result(input muldiv_op_t op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        r  = '0;
        case (op)
            OP_MUL:    begin p = 64'(sa * sb); r = p[31:0]; end
            OP_MULH:   begin p = 64'(sa * sb); r = p[63:32]; end
            OP_MULHSU: begin p = 64'(sa * ub); r = p[63:32]; end
            OP_MULHU:  begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            OP_DIV: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = 32'(sa / sb);
            end
            OP_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = 32'(sa % sb);
            end
            default:   r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic ref_fast(input muldiv_op_t op, input logic [31:0] a,
                                      input logic [31:0] b);
        logic is_signed_div;
        is_signed_div = (op == OP_DIV) || (op == OP_REM);
        if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU} && b == 0) return 1'b1;
        return is_signed_div && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'h1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            5:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
    endtask

    // Issues one op to both units, measures latency, optionally holds off the
    // consumer for `hold` cycles, then drains the response.
    task automatic run_op(input string tag, input muldiv_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic fast,
                          input int hold);
        int          lat1;
        int          lat4;
        logic [31:0] r1;
        logic [31:0] r4;
        logic        stable;
        lat1   = 0;
        lat4   = 0;
        stable = 1'b1;
        applyStimulus(op, a, b);
        checkOutput({tag, " ready"}, 32'({bus1.req_ready, bus4.req_ready}), 32'd3);
        for (int c = 1; c <= 100 && (lat1 == 0 || lat4 == 0); c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0;
                req_op    = muldiv_op_t'($urandom_range(0, 7));
                req_src1  = $urandom;
                req_src2  = $urandom;
            end
            if (lat1 == 0 && bus1.resp_valid) lat1 = c;
            if (lat4 == 0 && bus4.resp_valid) lat4 = c;
        end
        checkOutput({tag, " lat1"}, 32'(lat1), fast ? 32'd1 : 32'(LAT1));
        checkOutput({tag, " lat4"}, 32'(lat4), fast ? 32'd1 : 32'(LAT4));
        checkOutput({tag, " res1"}, bus1.resp_result, exp);
        checkOutput({tag, " res4"}, bus4.resp_result, exp);
        checkOutput({tag, " zero1"}, 32'(bus1.resp_zero), 32'(exp == 0));
        checkOutput({tag, " zero4"}, 32'(bus4.resp_zero), 32'(exp == 0));
        r1 = bus1.resp_result;
        r4 = bus4.resp_result;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (bus1.resp_result !== r1 || bus4.resp_result !== r4 || !bus1.resp_valid ||
                !bus4.resp_valid || bus1.req_ready || bus4.req_ready) stable = 1'b0;
        end
        if (hold > 0) checkOutput({tag, " hold"}, 32'(stable), 32'd1);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput({tag, " drain"},
                    32'({bus1.resp_valid, bus4.resp_valid, bus1.req_ready, bus4.req_ready}),
                    32'b0011);
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, " flags1"},
                    32'({bus1.req_ready, bus1.resp_valid, bus1.resp_zero, busy1}), 32'b1010);
        checkOutput({tag, " flags4"},
                    32'({bus4.req_ready, bus4.resp_valid, bus4.resp_zero, busy4}), 32'b1010);
        checkOutput({tag, " res1"}, bus1.resp_result, 32'h0);
        checkOutput({tag, " res4"}, bus4.resp_result, 32'h0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        muldiv_op_t  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          stray;

        vecs[0]  = '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
        vecs[2]  = '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{OP_DIVU,   32'hFFFF_FFFE, 32'h0000_0003, 32'h5555_5554, 1'b0};
        vecs[5]  = '{OP_REMU,   32'h0000_000A, 32'h0000_0003, 32'h0000_0001, 1'b0};
        vecs[6]  = '{OP_DIV,    32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{OP_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b1};
        vecs[8]  = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[9]  = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[10] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[11] = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[12] = '{OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[13] = '{OP_DIVU,   32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b0};
        vecs[14] = '{OP_DIV,    32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[15] = '{OP_MUL,    32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};

        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = OP_MUL;
        req_src1   = '0;
        req_src2   = '0;
        resp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                   vecs[i].fast, 0);
        end

        run_op("backpressure", OP_DIVU, 32'd1000, 32'd7, 32'd142, 1'b0, 10);

        for (int i = 0; i < 48; i++) begin
            rop = muldiv_op_t'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op($sformatf("rnd%0d op%0d %08h %08h", i, rop, ra, rb), rop, ra, rb,
                   ref_result(rop, ra, rb), ref_fast(rop, ra, rb), 0);
        end

        // Flush in cycle 5 of a divide: unit goes idle and the result never appears.
        applyStimulus(OP_DIV, 32'd1000, 32'd7);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush busy", 32'({busy1, busy4}), 32'b00);
        checkOutput("flush ready", 32'({bus1.req_ready, bus4.req_ready}), 32'b11);
        stray = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus1.resp_valid || bus4.resp_valid) stray = 1;
        end
        checkOutput("flush no resp", 32'(stray), 32'd0);
        run_op("after flush", OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, 0);

        // A request presented together with flush must not be accepted.
        applyStimulus(OP_DIV, 32'd9, 32'd3);
        flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        checkOutput("flush+req busy", 32'({busy1, busy4}), 32'b00);

        // Flush while a fast-path response waits in DONE drops resp_valid.
        applyStimulus(OP_DIV, 32'd9, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("done before flush", 32'({bus1.resp_valid, bus4.resp_valid}), 32'b11);
        flush      = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        flush      = 1'b0;
        resp_ready = 1'b0;
        checkOutput("done after flush", 32'({bus1.resp_valid, bus4.resp_valid, busy1, busy4}),
                    32'b0000);

        run_op("pre reset", OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, 0);

        // Asynchronous reset in the middle of an iteration.
        applyStimulus(OP_MUL, 32'd3, 32'd5);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
        end
        checkOutput("mid busy", 32'({busy1, busy4}), 32'b11);
        rst = 1'b1;
        #1;
        check_reset_values("async reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post reset idle", 32'({busy1, busy4}), 32'b00);
        run_op("post reset", OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
